// File: rtl/demux_1x2_reg.sv
// Registered 1-to-2 valid/ready demultiplexer with a one-word holding register per output.
// Optional per-output transfer counters are built when DEMUX_CNT_EN is defined.
module demux_1x2_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    logic [WIDTH-1:0] a_data_q, a_data_d;
    logic [WIDTH-1:0] b_data_q, b_data_d;
    logic             a_valid_q, a_valid_d;
    logic             b_valid_q, b_valid_d;

    logic a_space, b_space;
    logic a_fire, b_fire;
    logic in_fire, a_load, b_load;

    assign a_space  = ~a_valid_q | a_ready;
    assign b_space  = ~b_valid_q | b_ready;
    assign a_fire   = a_valid_q & a_ready;
    assign b_fire   = b_valid_q & b_ready;
    assign in_ready = in_sel ? a_space : b_space;
    assign in_fire  = in_valid & in_ready;
    assign a_load   = in_fire & in_sel;
    assign b_load   = in_fire & ~in_sel;

    // A load wins over a drain so a full register refills without a bubble.
    always_comb begin
        a_data_d  = a_data_q;
        a_valid_d = a_valid_q;
        b_data_d  = b_data_q;
        b_valid_d = b_valid_q;
        if (a_load) begin
            a_data_d  = in_data;
            a_valid_d = 1'b1;
        end else if (a_fire) begin
            a_valid_d = 1'b0;
        end
        if (b_load) begin
            b_data_d  = in_data;
            b_valid_d = 1'b1;
        end else if (b_fire) begin
            b_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_data_q  <= '0;
            a_valid_q <= 1'b0;
            b_data_q  <= '0;
            b_valid_q <= 1'b0;
        end else begin
            a_data_q  <= a_data_d;
            a_valid_q <= a_valid_d;
            b_data_q  <= b_data_d;
            b_valid_q <= b_valid_d;
        end
    end

    assign a_data  = a_data_q;
    assign a_valid = a_valid_q;
    assign b_data  = b_data_q;
    assign b_valid = b_valid_q;

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
    logic [CNT_W-1:0] b_cnt_q, b_cnt_d;

    always_comb begin
        a_cnt_d = a_cnt_q;
        b_cnt_d = b_cnt_q;
        if (a_fire) a_cnt_d = a_cnt_q + 1'b1;
        if (b_fire) b_cnt_d = b_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cnt_q <= '0;
            b_cnt_q <= '0;
        end else begin
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
        end
    end

    assign a_count = a_cnt_q;
    assign b_count = b_cnt_q;
`else
    assign a_count = '0;
    assign b_count = '0;
`endif

endmodule
